// File: rtl/dcsk_frame_ctrl_pkg.sv
// Shared types and constants for the DCSK frame controller.
package dcsk_pkg;
  localparam int unsigned DCSK_SPREAD_DEFAULT = 8;
  localparam int unsigned DCSK_FRAME_CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    REF,
    INFO
  } dcsk_frame_state_e;
endpackage

// File: rtl/dcsk_frame_ctrl_if.sv
// Bit-source, chaos-source and chip-sink handshakes of the DCSK frame controller.
interface dcsk_frame_ctrl_if;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;
  logic chaos_chip;
  logic chaos_valid;
  logic chaos_req;
  logic chip_out;
  logic chip_valid;
  logic chip_ready;
  logic chip_last;

  // master: surrounding datapath; slave: the frame controller
  modport master (
    output bit_in, bit_valid, chaos_chip, chaos_valid, chip_ready,
    input  bit_ready, chaos_req, chip_out, chip_valid, chip_last
  );
  modport slave (
    input  bit_in, bit_valid, chaos_chip, chaos_valid, chip_ready,
    output bit_ready, chaos_req, chip_out, chip_valid, chip_last
  );
endinterface

// File: rtl/dcsk_frame_ctrl_chip_delay.sv
// DEPTH-deep 1-bit shift register with enable; dout is the oldest entry.
module dcsk_chip_delay #(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n)
      sr <= '0;
    else if (shift_en)
      sr <= {sr[DEPTH-2:0], din};
  end

  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/dcsk_frame_ctrl.sv
// DCSK frame sequencer: SPREAD reference chips then SPREAD information chips per bit.
// Optional frame counter output enabled by `define DCSK_FRAME_CNT_EN.
module dcsk_frame_ctrl
  import dcsk_pkg::*;
#(
  parameter int unsigned SPREAD = DCSK_SPREAD_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  dcsk_frame_ctrl_if.slave             bus,
  output logic                         busy
`ifdef DCSK_FRAME_CNT_EN
  ,
  output logic [DCSK_FRAME_CNT_W-1:0]  frame_cnt
`endif
);
  localparam int unsigned CW = $clog2(SPREAD);
  localparam logic [CW-1:0] LAST = CW'(SPREAD - 1);

  dcsk_frame_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic bit_q, bit_q_nxt;
  logic dly_head, shift_en, dly_din;
  logic bit_ready_c, chaos_req_c, chip_out_c, chip_valid_c, chip_last_c, busy_c;
  logic frame_done;

  dcsk_chip_delay #(.DEPTH(SPREAD)) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .din      (dly_din),
    .dout     (dly_head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      bit_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      bit_q <= bit_q_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_q_nxt    = bit_q;
    bit_ready_c  = 1'b0;
    chaos_req_c  = 1'b0;
    chip_out_c   = 1'b0;
    chip_valid_c = 1'b0;
    chip_last_c  = 1'b0;
    busy_c       = 1'b0;
    shift_en     = 1'b0;
    dly_din      = 1'b0;
    frame_done   = 1'b0;
    case (state)
      IDLE: begin
        bit_ready_c = 1'b1;
        if (bus.bit_valid) begin
          bit_q_nxt = bus.bit_in;
          cnt_nxt   = '0;
          state_nxt = REF;
        end
      end
      REF: begin
        busy_c       = 1'b1;
        chip_valid_c = bus.chaos_valid;
        chip_out_c   = bus.chaos_chip;
        if (bus.chaos_valid && bus.chip_ready) begin
          chaos_req_c = 1'b1;
          shift_en    = 1'b1;
          dly_din     = bus.chaos_chip;
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = INFO;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      INFO: begin
        busy_c       = 1'b1;
        chip_valid_c = 1'b1;
        chip_out_c   = ~(dly_head ^ bit_q);
        chip_last_c  = (cnt == LAST);
        if (bus.chip_ready) begin
          shift_en = 1'b1;
          if (cnt == LAST) begin
            // accepting the next bit here gives back-to-back frames with no gap
            bit_ready_c = 1'b1;
            frame_done  = 1'b1;
            cnt_nxt     = '0;
            if (bus.bit_valid) begin
              bit_q_nxt = bus.bit_in;
              state_nxt = REF;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, even before the reset edge.
  assign bus.bit_ready  = rst_n & bit_ready_c;
  assign bus.chaos_req  = rst_n & chaos_req_c;
  assign bus.chip_out   = rst_n & chip_out_c;
  assign bus.chip_valid = rst_n & chip_valid_c;
  assign bus.chip_last  = rst_n & chip_last_c;
  assign busy           = rst_n & busy_c;

`ifdef DCSK_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      frame_cnt <= '0;
    else if (frame_done)
      frame_cnt <= frame_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_dcsk_frame_ctrl.sv
// Directed self-checking bench for dcsk_frame_ctrl with SPREAD=4.
module tb_dcsk_frame_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   vectors = 0;
  int   miscompares = 0;
`ifdef DCSK_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  dcsk_frame_ctrl_if bus();

  dcsk_frame_ctrl #(.SPREAD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy)
`ifdef DCSK_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // One chip transfer with chaos valid and sink ready.
  task automatic xfer(input string tag, input logic ch, input logic isref,
                      input logic exp_out, input logic exp_last);
    bus.chaos_chip  = ch;
    bus.chaos_valid = 1'b1;
    bus.chip_ready  = 1'b1;
    #1;
    chk({tag, "_valid"}, bus.chip_valid, 1'b1);
    chk({tag, "_out"},   bus.chip_out,   exp_out);
    chk({tag, "_last"},  bus.chip_last,  exp_last);
    chk({tag, "_req"},   bus.chaos_req,  isref);
    chk({tag, "_rdy"},   bus.bit_ready,  exp_last);
    chk({tag, "_busy"},  busy,           1'b1);
    tick();
  endtask

  task automatic accept(input string tag, input logic b);
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    #1;
    chk({tag, "_accept_rdy"}, bus.bit_ready, 1'b1);
    tick();
    bus.bit_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    #1;
    chk({tag, "_idle_valid"}, bus.chip_valid, 1'b0);
    chk({tag, "_idle_busy"},  busy,           1'b0);
    chk({tag, "_idle_rdy"},   bus.bit_ready,  1'b1);
  endtask

  // Full frame: ch holds reference chips first-chip-in-MSB, exp the 8 chips likewise.
  task automatic frame(input string tag, input logic b, input logic [3:0] ch,
                       input logic [7:0] exp);
    accept(tag, b);
    for (int i = 0; i < 8; i++)
      xfer($sformatf("%s_c%0d", tag, i), (i < 4) ? ch[3-i] : 1'b0, i < 4, exp[7-i], i == 7);
    check_idle(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n           = 1'b0;
    bus.bit_in      = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.chaos_chip  = 1'b0;
    bus.chaos_valid = 1'b0;
    bus.chip_ready  = 1'b0;
    tick();
    #1;
    chk("rst_bit_ready",  bus.bit_ready,  1'b0);
    chk("rst_chaos_req",  bus.chaos_req,  1'b0);
    chk("rst_chip_out",   bus.chip_out,   1'b0);
    chk("rst_chip_valid", bus.chip_valid, 1'b0);
    chk("rst_chip_last",  bus.chip_last,  1'b0);
    chk("rst_busy",       busy,           1'b0);
    tick();
    rst_n = 1'b1;
    check_idle("post_rst");

    // single frames
    frame("f1", 1'b1, 4'b1011, 8'b1011_1011);
    frame("f0", 1'b0, 4'b1011, 8'b1011_0100);

    // back-to-back: bits 1 then 0 with bit_valid held high
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    #1;
    chk("b2b_accept_rdy", bus.bit_ready, 1'b1);
    tick();
    xfer("b2b_c0", 1'b1, 1'b1, 1'b1, 1'b0);
    xfer("b2b_c1", 1'b0, 1'b1, 1'b0, 1'b0);
    xfer("b2b_c2", 1'b1, 1'b1, 1'b1, 1'b0);
    xfer("b2b_c3", 1'b1, 1'b1, 1'b1, 1'b0);
    bus.bit_in = 1'b0;
    xfer("b2b_c4", 1'b0, 1'b0, 1'b1, 1'b0);
    xfer("b2b_c5", 1'b0, 1'b0, 1'b0, 1'b0);
    xfer("b2b_c6", 1'b0, 1'b0, 1'b1, 1'b0);
    xfer("b2b_c7", 1'b0, 1'b0, 1'b1, 1'b1);
    xfer("b2b_c8", 1'b0, 1'b1, 1'b0, 1'b0);
    xfer("b2b_c9", 1'b0, 1'b1, 1'b0, 1'b0);
    xfer("b2b_c10", 1'b1, 1'b1, 1'b1, 1'b0);
    xfer("b2b_c11", 1'b0, 1'b1, 1'b0, 1'b0);
    xfer("b2b_c12", 1'b0, 1'b0, 1'b1, 1'b0);
    xfer("b2b_c13", 1'b0, 1'b0, 1'b1, 1'b0);
    xfer("b2b_c14", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.bit_valid = 1'b0;
    xfer("b2b_c15", 1'b0, 1'b0, 1'b1, 1'b1);
    check_idle("b2b");

    // backpressure: chip_ready low for 2 cycles at INFO chip 2
    accept("bp", 1'b1);
    xfer("bp_c0", 1'b1, 1'b1, 1'b1, 1'b0);
    xfer("bp_c1", 1'b0, 1'b1, 1'b0, 1'b0);
    xfer("bp_c2", 1'b1, 1'b1, 1'b1, 1'b0);
    xfer("bp_c3", 1'b1, 1'b1, 1'b1, 1'b0);
    xfer("bp_c4", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      bus.chip_ready = 1'b0;
      #1;
      chk($sformatf("bp_hold%0d_valid", i), bus.chip_valid, 1'b1);
      chk($sformatf("bp_hold%0d_out", i),   bus.chip_out,   1'b0);
      chk($sformatf("bp_hold%0d_last", i),  bus.chip_last,  1'b0);
      chk($sformatf("bp_hold%0d_rdy", i),   bus.bit_ready,  1'b0);
      tick();
    end
    xfer("bp_c5", 1'b0, 1'b0, 1'b0, 1'b0);
    xfer("bp_c6", 1'b0, 1'b0, 1'b1, 1'b0);
    xfer("bp_c7", 1'b0, 1'b0, 1'b1, 1'b1);
    check_idle("bp");

    // chaos starvation for 3 cycles at REF chip 1
    accept("st", 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.chaos_valid = 1'b0;
      bus.chaos_chip  = 1'b1;
      bus.chip_ready  = 1'b1;
      #1;
      chk($sformatf("st_wait%0d_valid", i), bus.chip_valid, 1'b0);
      chk($sformatf("st_wait%0d_req", i),   bus.chaos_req,  1'b0);
      chk($sformatf("st_wait%0d_busy", i),  busy,           1'b1);
      tick();
    end
    xfer("st_c0", 1'b0, 1'b1, 1'b0, 1'b0);
    xfer("st_c1", 1'b1, 1'b1, 1'b1, 1'b0);
    xfer("st_c2", 1'b1, 1'b1, 1'b1, 1'b0);
    xfer("st_c3", 1'b0, 1'b1, 1'b0, 1'b0);
    xfer("st_c4", 1'b0, 1'b0, 1'b1, 1'b0);
    xfer("st_c5", 1'b0, 1'b0, 1'b0, 1'b0);
    xfer("st_c6", 1'b0, 1'b0, 1'b0, 1'b0);
    xfer("st_c7", 1'b0, 1'b0, 1'b1, 1'b1);
    check_idle("st");

    // reset at INFO chip 1
    accept("rm", 1'b0);
    for (int i = 0; i < 4; i++)
      xfer($sformatf("rm_c%0d", i), 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n          = 1'b0;
    bus.chip_ready = 1'b1;
    #1;
    chk("rm_rst_valid", bus.chip_valid, 1'b0);
    chk("rm_rst_out",   bus.chip_out,   1'b0);
    chk("rm_rst_last",  bus.chip_last,  1'b0);
    chk("rm_rst_rdy",   bus.bit_ready,  1'b0);
    chk("rm_rst_req",   bus.chaos_req,  1'b0);
    chk("rm_rst_busy",  busy,           1'b0);
    tick();
    rst_n = 1'b1;
    check_idle("rm");
    frame("rf", 1'b1, 4'b1100, 8'b1100_1100);

`ifdef DCSK_FRAME_CNT_EN
    #1;
    chk("frame_cnt", frame_cnt, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
